// File: rtl/vga_pkg.sv
// Purpose: shared VGA timing, tile-map geometry and fetch FSM encoding.
// Latency: n/a (constants, types and a pure index helper).
// Backpressure: n/a.
package vga_pkg;

  localparam int ACTIVE_COLS = 640;
  localparam int ACTIVE_ROWS = 480;
  localparam int TOTAL_COLS  = 800;
  localparam int TOTAL_ROWS  = 525;

  localparam int TILE_WIDTH  = 32;
  localparam int TILE_HEIGHT = 32;
  localparam int MAP_COLS    = 20;
  localparam int MAP_ROWS    = 15;
  localparam int MAP_DEPTH   = 300;
  localparam int MAP_ADDR_W  = 9;
  localparam int SPRITE_W    = 4;

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_RUN   = 1'b1
  } fetch_state_t;

  // row*20 + col built from two shifts so no multiplier is inferred.
  function automatic logic [MAP_ADDR_W-1:0] map_index(input logic [4:0] tile_col,
                                                      input logic [4:0] tile_row);
    logic [MAP_ADDR_W-1:0] row_ext;
    logic [MAP_ADDR_W-1:0] col_ext;
    row_ext = {4'b0000, tile_row};
    col_ext = {4'b0000, tile_col};
    return (row_ext << 4) + (row_ext << 2) + col_ext;
  endfunction

endpackage

// File: rtl/tile_map_ram.sv
// Purpose: 300x4 single-port tile-map store with registered read data.
// Latency: 1 cycle address-to-data; read data holds on write cycles.
// Backpressure: none; a write occupies the port and the read is skipped.
module tile_map_ram
  import vga_pkg::*;
(
  input  logic                  i_Clk,
  input  logic                  i_We,
  input  logic [MAP_ADDR_W-1:0] i_Addr,
  input  logic [SPRITE_W-1:0]   i_Wr_Data,
  output logic [SPRITE_W-1:0]   o_Rd_Data
);

  logic [SPRITE_W-1:0] mem [MAP_DEPTH];

  // One access per cycle: write takes the port, otherwise a guarded read.
  always_ff @(posedge i_Clk) begin
    if (i_We) begin
      if (i_Addr < MAP_ADDR_W'(MAP_DEPTH)) begin
        mem[i_Addr] <= i_Wr_Data;
      end
    end else if (i_Addr < MAP_ADDR_W'(MAP_DEPTH)) begin
      o_Rd_Data <= mem[i_Addr];
    end else begin
      o_Rd_Data <= '0;
    end
  end

endmodule

// File: rtl/tile_map_fetch.sv
// Purpose: split pixel counters into tile offset + tile-map sprite lookup for the sprite stage.
// Latency: 2 cycles from counter/sync sample to outputs, all outputs registered.
// Backpressure: map writes are ready only in blanking after the post-reset clear.
module tile_map_fetch
  import vga_pkg::*;
#(
  parameter int TILE_WIDTH  = vga_pkg::TILE_WIDTH,
  parameter int TILE_HEIGHT = vga_pkg::TILE_HEIGHT,
  parameter int ACTIVE_COLS = vga_pkg::ACTIVE_COLS,
  parameter int ACTIVE_ROWS = vga_pkg::ACTIVE_ROWS,
  parameter int MAP_COLS    = vga_pkg::MAP_COLS,
  parameter int MAP_ROWS    = vga_pkg::MAP_ROWS
) (
  input  logic          i_Clk,
  input  logic          i_Rst_L,
  input  logic [9:0]    i_Col_Count,
  input  logic [9:0]    i_Row_Count,
  input  logic          i_HSync,
  input  logic          i_VSync,
  input  logic          i_Wr_Valid,
  output logic          o_Wr_Ready,
  input  logic [4:0]    i_Wr_Col,
  input  logic [3:0]    i_Wr_Row,
  input  logic [3:0]    i_Wr_Sprite,
  output logic          o_Wr_Err,
  output logic [4:0]    o_Local_X,
  output logic [4:0]    o_Local_Y,
  output logic [3:0]    o_Sprite,
  output logic          o_Active,
  output logic          o_HSync,
  output logic          o_VSync
);

  localparam int TX = $clog2(TILE_WIDTH);
  localparam int TY = $clog2(TILE_HEIGHT);

  fetch_state_t          state;
  logic [MAP_ADDR_W-1:0] clr_addr;

  logic                  blanking;
  logic                  wr_accept;
  logic                  wr_in_range;
  logic [MAP_ADDR_W-1:0] wr_index;
  logic [4:0]            rd_tile_col;
  logic [4:0]            rd_tile_row;
  logic [MAP_ADDR_W-1:0] rd_index;

  logic                  ram_we;
  logic [MAP_ADDR_W-1:0] ram_addr;
  logic [SPRITE_W-1:0]   ram_wdata;
  logic [SPRITE_W-1:0]   ram_rd;

  logic [4:0]            s1_local_x;
  logic [4:0]            s1_local_y;
  logic                  s1_active;
  logic                  s1_rd_ok;
  logic                  s1_hsync;
  logic                  s1_vsync;

  assign blanking    = (i_Col_Count >= 10'(ACTIVE_COLS)) || (i_Row_Count >= 10'(ACTIVE_ROWS));
  assign o_Wr_Ready  = i_Rst_L && (state == ST_RUN) && blanking;
  assign wr_accept   = i_Wr_Valid && o_Wr_Ready;
  assign wr_in_range = (i_Wr_Col < 5'(MAP_COLS)) && (i_Wr_Row < 4'(MAP_ROWS));
  assign wr_index    = map_index(i_Wr_Col, {1'b0, i_Wr_Row});

  // Read index comes from the live counters so a stolen read slot always
  // belongs to a blanking pixel (the same cycle that made ready high).
  assign rd_tile_col = 5'(i_Col_Count >> TX);
  assign rd_tile_row = 5'(i_Row_Count >> TY);
  assign rd_index    = map_index(rd_tile_col, rd_tile_row);

  // Port arbitration: clear, then accepted in-range writes, else the pixel read.
  always_comb begin
    ram_we    = 1'b0;
    ram_addr  = rd_index;
    ram_wdata = '0;
    if (state == ST_CLEAR) begin
      ram_we   = 1'b1;
      ram_addr = clr_addr;
    end else if (wr_accept && wr_in_range) begin
      ram_we    = 1'b1;
      ram_addr  = wr_index;
      ram_wdata = i_Wr_Sprite;
    end
  end

  tile_map_ram u_ram (
    .i_Clk     (i_Clk),
    .i_We      (ram_we),
    .i_Addr    (ram_addr),
    .i_Wr_Data (ram_wdata),
    .o_Rd_Data (ram_rd)
  );

  // Clear-then-run FSM: sweep every map entry to sprite 0 after each reset.
  always_ff @(posedge i_Clk) begin
    if (!i_Rst_L) begin
      state    <= ST_CLEAR;
      clr_addr <= '0;
    end else begin
      case (state)
        ST_CLEAR: begin
          clr_addr <= clr_addr + 1'b1;
          if (clr_addr == MAP_ADDR_W'(MAP_DEPTH - 1)) begin
            state <= ST_RUN;
          end
        end
        default: state <= ST_RUN;
      endcase
    end
  end

  // Stage 1: capture offsets, visibility, syncs, and whether the RAM read is real.
  always_ff @(posedge i_Clk) begin
    if (!i_Rst_L) begin
      s1_local_x <= '0;
      s1_local_y <= '0;
      s1_active  <= 1'b0;
      s1_rd_ok   <= 1'b0;
      s1_hsync   <= 1'b1;
      s1_vsync   <= 1'b1;
    end else begin
      s1_local_x <= i_Col_Count[4:0];
      s1_local_y <= i_Row_Count[4:0];
      s1_active  <= !blanking;
      s1_rd_ok   <= (state == ST_RUN) && !ram_we;
      s1_hsync   <= i_HSync;
      s1_vsync   <= i_VSync;
    end
  end

  // Stage 2: masked outputs so blanking and clear never show stale sprite IDs.
  always_ff @(posedge i_Clk) begin
    if (!i_Rst_L) begin
      o_Local_X <= '0;
      o_Local_Y <= '0;
      o_Sprite  <= '0;
      o_Active  <= 1'b0;
      o_HSync   <= 1'b1;
      o_VSync   <= 1'b1;
    end else begin
      o_Local_X <= s1_active ? s1_local_x : 5'd0;
      o_Local_Y <= s1_active ? s1_local_y : 5'd0;
      o_Sprite  <= (s1_active && s1_rd_ok) ? ram_rd : 4'd0;
      o_Active  <= s1_active;
      o_HSync   <= s1_hsync;
      o_VSync   <= s1_vsync;
    end
  end

  // Error flag: one-cycle pulse after an accepted write that missed the map.
  always_ff @(posedge i_Clk) begin
    if (!i_Rst_L) begin
      o_Wr_Err <= 1'b0;
    end else begin
      o_Wr_Err <= wr_accept && !wr_in_range;
    end
  end

endmodule

// File: tb/tb_tile_map_fetch.sv
// Purpose: scoreboard bench for tile_map_fetch against a behavioural tile-map model.
// Latency: expectations queued at drive time, popped two cycles later.
// Backpressure: bench holds write requests until its own model predicts ready.
module tb_tile_map_fetch;

  logic       clk = 1'b0;
  logic       rst_l;
  logic [9:0] col, row;
  logic       hs, vs;
  logic       wv;
  logic [4:0] wc;
  logic [3:0] wr;
  logic [3:0] ws;
  logic       wr_ready, wr_err;
  logic [4:0] lx, ly;
  logic [3:0] spr;
  logic       act, ohs, ovs;

  always #20 clk = ~clk;

  tile_map_fetch dut (
    .i_Clk       (clk),
    .i_Rst_L     (rst_l),
    .i_Col_Count (col),
    .i_Row_Count (row),
    .i_HSync     (hs),
    .i_VSync     (vs),
    .i_Wr_Valid  (wv),
    .o_Wr_Ready  (wr_ready),
    .i_Wr_Col    (wc),
    .i_Wr_Row    (wr),
    .i_Wr_Sprite (ws),
    .o_Wr_Err    (wr_err),
    .o_Local_X   (lx),
    .o_Local_Y   (ly),
    .o_Sprite    (spr),
    .o_Active    (act),
    .o_HSync     (ohs),
    .o_VSync     (ovs)
  );

  typedef struct {
    logic [4:0] lx;
    logic [4:0] ly;
    logic [3:0] spr;
    logic       act;
    logic       hs;
    logic       vs;
  } exp_t;

  exp_t       exp_q[$];
  logic [3:0] model_map [300];
  int         clr_edges = 0;
  logic       prev_err = 1'b0;
  bit         err_armed = 0;
  bit         last_accept = 0;
  int         n_checks = 0;
  int         n_fail = 0;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_checks++;
    if (obs !== expv) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, expv, $time);
    end
  endtask

  // One pixel-clock step: drive inputs, predict, then check outputs at negedge.
  task automatic drive(input logic r, input int c, input int rw, input logic h, input logic v,
                       input logic wvalid, input int wcol, input int wrow, input int wspr);
    bit   run, blank, exp_ready, accept, inr, err_now;
    int   idx;
    exp_t e, rst_e;
    @(posedge clk);
    #1;
    rst_l = r; col = 10'(c); row = 10'(rw); hs = h; vs = v;
    wv = wvalid; wc = 5'(wcol); wr = 4'(wrow); ws = 4'(wspr);
    #1;
    run       = r && (clr_edges >= 300);
    blank     = (c >= 640) || (rw >= 480);
    exp_ready = run && blank;
    check_val("wr_ready", {31'b0, wr_ready}, {31'b0, exp_ready});
    accept = wvalid && exp_ready;
    inr    = (wcol < 20) && (wrow < 15);

    rst_e.lx = 0; rst_e.ly = 0; rst_e.spr = 0; rst_e.act = 0; rst_e.hs = 1; rst_e.vs = 1;
    if (!r) begin
      e = rst_e;
      if (exp_q.size() > 0) exp_q[exp_q.size()-1] = rst_e;
    end else begin
      e.act = !blank;
      e.lx  = e.act ? 5'(c % 32) : 5'd0;
      e.ly  = e.act ? 5'(rw % 32) : 5'd0;
      idx   = (rw / 32) * 20 + (c / 32);
      e.spr = (e.act && run) ? model_map[idx] : 4'd0;
      e.hs  = h;
      e.vs  = v;
    end
    exp_q.push_back(e);

    if (accept && inr) model_map[wrow * 20 + wcol] = 4'(wspr);
    err_now = accept && !inr;
    if (!r) begin
      clr_edges = 0;
      for (int i = 0; i < 300; i++) model_map[i] = 4'd0;
    end else begin
      clr_edges++;
    end

    @(negedge clk);
    if (err_armed) check_val("wr_err", {31'b0, wr_err}, {31'b0, prev_err});
    prev_err  = err_now;
    err_armed = 1;
    if (exp_q.size() > 2) begin
      exp_t x;
      x = exp_q.pop_front();
      check_val("local_x", {27'b0, lx}, {27'b0, x.lx});
      check_val("local_y", {27'b0, ly}, {27'b0, x.ly});
      check_val("sprite", {28'b0, spr}, {28'b0, x.spr});
      check_val("active", {31'b0, act}, {31'b0, x.act});
      check_val("hsync", {31'b0, ohs}, {31'b0, x.hs});
      check_val("vsync", {31'b0, ovs}, {31'b0, x.vs});
    end
    last_accept = accept;
  endtask

  int rows_t [5] = '{63, 64, 80, 95, 96};
  int cols_t [5] = '{95, 96, 110, 127, 128};

  initial begin
    logic       hold_v;
    logic [4:0] hc;
    logic [3:0] hr, hsp;
    rst_l = 1'b0; col = '0; row = '0; hs = 1'b1; vs = 1'b1;
    wv = 1'b0; wc = '0; wr = '0; ws = '0;
    for (int i = 0; i < 300; i++) model_map[i] = 4'd0;

    // Reset, then the clear window over a mix of visible and blanking pixels.
    for (int i = 0; i < 4; i++) drive(0, 0, 0, 1, 1, 0, 0, 0, 0);
    for (int i = 0; i < 320; i++)
      drive(1, (i * 37) % 800, (i * 11) % 525, (i % 3) != 0, (i % 5) != 0, 0, 0, 0, 0);

    // Blanking write of tile (3,2), then a neighbourhood read around it.
    drive(1, 700, 10, 1, 1, 1, 3, 2, 4);
    foreach (rows_t[ri])
      foreach (cols_t[ci])
        drive(1, cols_t[ci], rows_t[ri], 1, 1, 0, 0, 0, 0);

    // Offset/index check at col 100, row 37 (index 23 holds sprite 9).
    drive(1, 650, 40, 1, 1, 1, 3, 1, 9);
    drive(1, 100, 37, 0, 1, 0, 0, 0, 0);
    drive(1, 101, 37, 1, 0, 0, 0, 0, 0);

    // Write held through a visible line; lands at col 640.
    hold_v = 1'b1;
    for (int c = 10; c <= 660; c++) begin
      drive(1, c, 160, 1, 1, hold_v, 5, 5, 7);
      if (last_accept) hold_v = 1'b0;
    end
    drive(1, 170, 165, 1, 1, 0, 0, 0, 0);
    drive(1, 191, 191, 1, 1, 0, 0, 0, 0);

    // Out-of-range write: completes, pulses error, leaves tile 20 alone.
    drive(1, 700, 300, 1, 1, 1, 20, 0, 1);
    drive(1, 0, 32, 1, 1, 0, 0, 0, 0);
    drive(1, 5, 40, 1, 1, 0, 0, 0, 0);
    drive(1, 700, 490, 1, 1, 0, 0, 0, 0);

    // Random pixels, syncs and held write requests.
    hold_v = 1'b0; hc = '0; hr = '0; hsp = '0;
    for (int i = 0; i < 400; i++) begin
      if (!hold_v && ($urandom_range(0, 3) == 0)) begin
        hold_v = 1'b1;
        hc     = 5'($urandom_range(0, 23));
        hr     = 4'($urandom_range(0, 15));
        hsp    = 4'($urandom_range(0, 15));
      end
      drive(1, $urandom_range(0, 799), $urandom_range(0, 524), 1'($urandom_range(0, 1)),
            1'($urandom_range(0, 1)), hold_v, hc, hr, hsp);
      if (last_accept) hold_v = 1'b0;
    end

    // Reset partway through the clear restarts it from address 0.
    drive(0, 700, 500, 1, 1, 0, 0, 0, 0);
    drive(0, 700, 500, 1, 1, 0, 0, 0, 0);
    for (int i = 0; i < 150; i++) drive(1, 700, 500, 1, 1, 1, 5, 5, 3);
    drive(0, 700, 500, 1, 1, 1, 5, 5, 3);
    hold_v = 1'b1;
    for (int i = 0; i < 305; i++) begin
      drive(1, 700, 500, 1, 1, hold_v, 5, 5, 3);
      if (last_accept) hold_v = 1'b0;
    end
    drive(1, 170, 170, 1, 1, 0, 0, 0, 0);
    drive(1, 100, 37, 1, 1, 0, 0, 0, 0);
    drive(1, 700, 500, 0, 0, 0, 0, 0, 0);
    drive(1, 700, 500, 1, 1, 0, 0, 0, 0);
    drive(1, 700, 500, 1, 1, 0, 0, 0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
